// File: rtl/ripple_down_pkg.sv
// Shared types for the ripple down-counter.
// Control states and the default counter width.
package ripple_down_pkg;

  localparam int WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ripple_down_counter_if.sv
// Control and status bundle of the down-counter.
// master drives controls, slave is the counter.
interface ripple_down_counter_if
  import ripple_down_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             en;
  logic             start;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             mode;
  logic [WIDTH-1:0] data_out;
  logic             tc;
  logic             busy;

  modport master (
    output en,
    output start,
    output load,
    output load_val,
    output mode,
    input  data_out,
    input  tc,
    input  busy
  );

  modport slave (
    input  en,
    input  start,
    input  load,
    input  load_val,
    input  mode,
    output data_out,
    output tc,
    output busy
  );

endinterface

// File: rtl/ripple_down_counter_tff.sv
// One counter bit: toggle flop with load.
// Resets to 1 so the counter comes up all-ones.
module tff_stage (
  input  logic clk,
  input  logic rst,
  input  logic t_i,
  input  logic ld_i,
  input  logic d_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  // load wins over toggle
  always_comb begin
    q_d = q_q ^ t_i;
    if (ld_i) q_d = d_i;
  end

  // bit register, async preset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= 1'b1;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/ripple_down_counter.sv
// Down-counter built from toggle stages with a
// borrow chain; one-shot or auto-reload control.
module ripple_down_counter
  import ripple_down_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic             clk,
  input logic             rst,
  ripple_down_counter_if.slave bus
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;
  logic             tc_q;
  logic             tc_d;
  logic             ld_en;
  logic [WIDTH-1:0] ld_data;
  logic [WIDTH-1:0] borrow;
  logic             run_en;
  logic             zero;
  logic             term;

  assign zero   = (cnt_q == '0);
  assign run_en = (state_q == RUN) && bus.en;
  // load pre-empts the terminal event
  assign term   = run_en && zero && !bus.load;

  // borrow ripple: bit i flips when all lower bits are 0
  assign borrow[0] = run_en && !zero && !bus.load;
  for (genvar i = 1; i < WIDTH; i++) begin : g_borrow
    assign borrow[i] = borrow[i-1] && !cnt_q[i-1];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_stage u_bit (
      .clk  (clk),
      .rst  (rst),
      .t_i  (borrow[i]),
      .ld_i (ld_en),
      .d_i  (ld_data[i]),
      .q_o  (cnt_q[i])
    );
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.load) begin
      state_d = bus.start ? RUN : IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (bus.start) state_d = RUN;
        RUN:  if (term && !bus.mode) state_d = DONE;
        DONE: if (bus.start) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // datapath controls derived from state and inputs
  always_comb begin
    ld_en = bus.load
         || (term && bus.mode)
         || (state_q == DONE && bus.start);
    ld_data  = bus.load ? bus.load_val : reload_q;
    reload_d = bus.load ? bus.load_val : reload_q;
    tc_d     = term;
  end

  // reload value and terminal-count pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_q <= '1;
      tc_q     <= 1'b0;
    end else begin
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign bus.data_out = cnt_q;
  assign bus.tc       = tc_q;
  assign bus.busy     = (state_q == RUN);

endmodule

// File: tb/tb_ripple_down_counter.sv
// Random and directed stimulus for the down-counter,
// checked through a scoreboard against a cycle model.
module tb_ripple_down_counter;

  localparam int W    = 3;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ripple_down_counter_if #(.WIDTH(W)) bus ();

  ripple_down_counter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int    cnt;
    bit    tc;
    bit    busy;
    string tag;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  // reference model: 0 idle, 1 run, 2 done
  int m_cnt;
  int m_rel;
  int m_st;
  bit m_tc;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic bound_fail(string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=reached", name);
  endtask

  task automatic model_reset();
    m_cnt = MAXV;
    m_rel = MAXV;
    m_st  = 0;
    m_tc  = 0;
  endtask

  task automatic model_step(bit en, bit st, bit ld, int lv, bit md);
    m_tc = 0;
    if (ld) begin
      m_cnt = lv;
      m_rel = lv;
      m_st  = st ? 1 : 0;
    end else if (m_st == 0) begin
      if (st) m_st = 1;
    end else if (m_st == 1) begin
      if (en) begin
        if (m_cnt == 0) begin
          m_tc = 1;
          if (md) m_cnt = m_rel;
          else    m_st = 2;
        end else begin
          m_cnt = (m_cnt - 1) % (MAXV + 1);
        end
      end
    end else begin
      if (st) begin
        m_cnt = m_rel;
        m_st  = 1;
      end
    end
  endtask

  task automatic push(string tag);
    exp_t e;
    e.cnt  = m_cnt;
    e.tc   = m_tc;
    e.busy = (m_st == 1);
    e.tag  = tag;
    sbq.push_back(e);
  endtask

  // one clock of stimulus, expectation queued
  task automatic cyc(bit en, bit st, bit ld, int lv, bit md,
                     string tag);
    @(negedge clk);
    rst          = 1'b0;
    bus.en       = en;
    bus.start    = st;
    bus.load     = ld;
    bus.load_val = lv[W-1:0];
    bus.mode     = md;
    model_step(en, st, ld, lv, md);
    push(tag);
  endtask

  // async reset, checked before any clock edge
  task automatic do_reset(string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk({tag, ".async_dout"}, int'(bus.data_out), MAXV);
    chk({tag, ".async_tc"}, int'(bus.tc), 0);
    chk({tag, ".async_busy"}, int'(bus.busy), 0);
    model_reset();
    push(tag);
  endtask

  // monitor: compare every cycle the DUT presents
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk({e.tag, ".dout"}, int'(bus.data_out), e.cnt);
        chk({e.tag, ".tc"}, int'(bus.tc), int'(e.tc));
        chk({e.tag, ".busy"}, int'(bus.busy), int'(e.busy));
      end
    end
  end

  initial begin
    int n;
    int tcs;
    bus.en       = 1'b0;
    bus.start    = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.mode     = 1'b0;
    model_reset();

    // one-shot from reset value 7
    do_reset("rst0");
    cyc(1, 1, 0, 0, 0, "os_start");
    tcs = 0;
    for (int i = 0; i < 11; i++) begin
      cyc(1, 0, 0, 0, 0, "os_run");
      if (m_tc) tcs++;
    end
    chk("os_tc_model_count", tcs, 1);

    // auto-reload, load-and-go with 3
    cyc(1, 1, 1, 3, 1, "ar_ldgo");
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, 1, "ar_run");

    // reload of 0: tc every cycle
    cyc(1, 1, 1, 0, 1, "ar0_ldgo");
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1, "ar0_run");

    // pause at 5
    cyc(1, 1, 1, 7, 0, "pause_ldgo");
    n = 0;
    while (m_cnt != 5 && n < 20) begin
      cyc(1, 0, 0, 0, 0, "pause_run");
      n++;
    end
    if (m_cnt != 5) bound_fail("pause_reach5");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, "pause_hold");
    for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0, 0, "pause_resume");

    // load on the terminal cycle
    n = 0;
    while (!(m_cnt == 0 && m_st == 1) && n < 20) begin
      cyc(1, 0, 0, 0, 0, "ldterm_run");
      n++;
    end
    if (!(m_cnt == 0 && m_st == 1)) bound_fail("ldterm_reach0");
    cyc(1, 0, 1, 2, 0, "ldterm_load");
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, "ldterm_idle");

    // reset at data_out 1
    cyc(1, 1, 1, 4, 0, "rstmid_ldgo");
    n = 0;
    while (m_cnt != 1 && n < 20) begin
      cyc(1, 0, 0, 0, 0, "rstmid_run");
      n++;
    end
    if (m_cnt != 1) bound_fail("rstmid_reach1");
    cyc(1, 0, 0, 0, 0, "rstmid_at1");
    do_reset("rstmid");
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, "rstmid_idle");

    // DONE restart reloads last loaded value
    cyc(1, 1, 1, 5, 0, "done_ldgo");
    cyc(1, 1, 0, 0, 0, "done_start_in_run");
    cyc(1, 1, 0, 0, 0, "done_start_in_run");
    n = 0;
    while (m_st != 2 && n < 20) begin
      cyc(1, 0, 0, 0, 0, "done_run");
      n++;
    end
    if (m_st != 2) bound_fail("done_reach");
    cyc(1, 0, 0, 0, 0, "done_hold");
    cyc(1, 1, 0, 0, 0, "done_restart");
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, "done_rerun");

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rnd_rst");
      end else begin
        cyc($urandom_range(0, 3) != 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 11) == 0,
            int'($urandom_range(0, MAXV)),
            $urandom_range(0, 1) == 1,
            "rnd");
      end
    end

    cyc(0, 0, 0, 0, 0, "drain");
    n = 0;
    while (sbq.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (sbq.size() > 0) bound_fail("scoreboard_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
